// File: rtl/divider_16bit_mul_check_if.sv
// Handshake bundle for the multiply-back check stage: operand side
// (quotient/divisor/remainder/expected dividend) and result side.
interface divider_16bit_mul_check_if #(
    parameter int Q_W = 16,
    parameter int B_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [Q_W-1:0]     quotient;
    logic [B_W-1:0]     divisor;
    logic [Q_W-1:0]     remainder;
    logic [Q_W-1:0]     dividend;
    logic               out_valid;
    logic               out_ready;
    logic [Q_W+B_W-1:0] result;
    logic               match;

    modport master (
        output in_valid, quotient, divisor, remainder, dividend, out_ready,
        input  in_ready, out_valid, result, match
    );

    modport slave (
        input  in_valid, quotient, divisor, remainder, dividend, out_ready,
        output in_ready, out_valid, result, match
    );
endinterface

// File: rtl/divider_16bit_mul_check.sv
// Rebuilds a dividend as quotient*divisor + remainder with an iterative
// shift-add (one divisor bit per cycle, fixed latency) and flags whether
// it equals the supplied expected dividend.
module divider_16bit_mul_check #(
    parameter int Q_W = 16,
    parameter int B_W = 8
) (
    input logic clk,
    input logic rst,
    divider_16bit_mul_check_if.slave bus
);
    localparam int A_W   = Q_W + B_W;
    localparam int CNT_W = $clog2(B_W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [A_W-1:0]   acc, mcand, acc_sum, result_q;
    logic [B_W-1:0]   mplier;
    logic [Q_W-1:0]   exp_q;
    logic [CNT_W-1:0] count;
    logic             match_q;
    logic             accept, last_iter;

    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_iter = (count == CNT_W'(B_W - 1));
    // Partial product step for the current multiplier bit.
    assign acc_sum   = mplier[0] ? (acc + mcand) : acc;

    assign bus.result = result_q;
    assign bus.match  = match_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, shift-add iteration and result/match latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            exp_q    <= '0;
            count    <= '0;
            result_q <= '0;
            match_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= A_W'(bus.remainder);
                        mcand  <= A_W'(bus.quotient);
                        mplier <= bus.divisor;
                        exp_q  <= bus.dividend;
                        count  <= '0;
                    end
                end
                BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    // Result is latched on the final step so it holds
                    // through DONE and afterwards until the next finish.
                    if (last_iter) begin
                        result_q <= acc_sum;
                        match_q  <= (acc_sum == {{B_W{1'b0}}, exp_q});
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_16bit_mul_check.sv
// Directed bench for divider_16bit_mul_check: arithmetic model with an
// expected-result queue, per-cycle output compare, plus literal checks.
module tb_divider_16bit_mul_check;
    localparam int Q_W = 16;
    localparam int B_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    divider_16bit_mul_check_if #(.Q_W(Q_W), .B_W(B_W)) bus ();

    divider_16bit_mul_check #(.Q_W(Q_W), .B_W(B_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [23:0] q_res[$];
    bit          q_match[$];

    function automatic logic [23:0] model_res(input logic [15:0] q, input logic [7:0] b,
                                              input logic [15:0] r);
        return 24'(q) * 24'(b) + 24'(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Model: queue the expected result for every accepted operand set.
    always @(posedge clk) begin
        if (rst) begin
            q_res.delete();
            q_match.delete();
        end else begin
            if (bus.out_valid && bus.out_ready && q_res.size() > 0) begin
                void'(q_res.pop_front());
                void'(q_match.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                q_res.push_back(model_res(bus.quotient, bus.divisor, bus.remainder));
                q_match.push_back(model_res(bus.quotient, bus.divisor, bus.remainder)
                                  == {8'h00, bus.dividend});
            end
        end
    end

    // Compare DUT output against the model whenever a result is presented.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            total++;
            if (q_res.size() == 0) begin
                bad++;
                $display("FAIL model_cmp: out_valid with nothing outstanding, result=%0h", bus.result);
            end else if (bus.result !== q_res[0] || bus.match !== q_match[0]) begin
                bad++;
                $display("FAIL model_cmp: got result=%0h match=%0b expected result=%0h match=%0b",
                         bus.result, bus.match, q_res[0], q_match[0]);
            end
        end
    end

    task automatic run_op(input logic [15:0] q, input logic [7:0] b, input logic [15:0] r,
                          input logic [15:0] a, input logic [23:0] er, input bit em,
                          input int hold, input bit junk);
        int cnt;
        @(negedge clk);
        bus.quotient  = q;
        bus.divisor   = b;
        bus.remainder = r;
        bus.dividend  = a;
        bus.in_valid  = 1'b1;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (junk) begin
                bus.in_valid  = 1'b1;
                bus.quotient  = q ^ 16'h5A5A;
                bus.divisor   = ~b;
                bus.remainder = r + 16'd1;
                bus.dividend  = ~a;
                check("in_ready_busy", 32'(bus.in_ready), 32'd0);
            end else begin
                bus.in_valid = 1'b0;
            end
        end while (!bus.out_valid && cnt < 40);
        check("latency", 32'(cnt), 32'd9);
        check("result", 32'(bus.result), 32'(er));
        check("match", 32'(bus.match), 32'(em));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_result", 32'(bus.result), 32'(er));
            check("hold_match", 32'(bus.match), 32'(em));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_valid", 32'(bus.out_valid), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.quotient  = '0;
        bus.divisor   = '0;
        bus.remainder = '0;
        bus.dividend  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_match", 32'(bus.match), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_op(16'h1234, 8'h56, 16'h0010, 16'h0000, 24'h061D88, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 8'hFF, 16'hFFFF, 16'h0000, 24'hFFFF00, 1'b0, 0, 1'b0);
        run_op(16'hABCD, 8'h00, 16'h0042, 16'h0000, 24'h000042, 1'b0, 0, 1'b0);
        run_op(16'd142, 8'd7, 16'd6, 16'd1000, 24'd1000, 1'b1, 0, 1'b0);
        run_op(16'd142, 8'd7, 16'd6, 16'd1001, 24'd1000, 1'b0, 0, 1'b0);
        run_op(16'h0000, 8'h9C, 16'h0777, 16'h0777, 24'h000777, 1'b1, 0, 1'b0);
        // Backpressure with garbage operands driven throughout BUSY/DONE.
        run_op(16'd142, 8'd7, 16'd6, 16'd1000, 24'd1000, 1'b1, 5, 1'b1);

        // Reset in the 4th BUSY cycle discards the operation.
        @(negedge clk);
        bus.quotient  = 16'd9;
        bus.divisor   = 8'd9;
        bus.remainder = 16'd9;
        bus.dividend  = 16'd0;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_result", 32'(bus.result), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        run_op(16'd3, 8'd5, 16'd1, 16'd16, 24'd16, 1'b1, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/divider_16bit_mul_check.md
Name: divider_16bit_mul_check

Overview:
- Sequential inverse of the 16-by-8 divider: rebuilds the dividend from the divider's outputs as quotient*divisor + remainder.
- Uses an iterative shift-add, one divisor bit per cycle.
- Also flags whether the rebuilt value equals a supplied expected dividend.
- Sits beside the divider as an in-line self-check / reconstruction stage, with valid/ready handshakes on both sides.

Parameters:
- Q_W, 16, width of quotient, remainder and expected dividend.
- B_W, 8, width of divisor; also the number of BUSY iterations.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- quotient  input  Q_W  multiplicand Q
- divisor  input  B_W  multiplier B
- remainder  input  Q_W  addend R
- dividend  input  Q_W  expected value A for comparison
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  Q_W+B_W  Q*B+R, unsigned
- match  output  1  result == zero-extended dividend

Behaviour:
- One clock, synchronous active-high reset. Reset applies when rst is sampled high at a clk edge and overrides all other inputs.
- Reset values: state IDLE, out_valid 0, result 0, match 0, internal count 0. in_ready reads 1 from the first cycle after reset.
- States:
  - IDLE: in_ready=1, out_valid=0. Accept when in_valid&&in_ready. On accept:
    - acc <= zero-extended remainder
    - mcand <= zero-extended quotient (Q_W+B_W bits)
    - mplier <= divisor
    - exp <= dividend
    - count <= 0
    - next state BUSY
  - BUSY: in_ready=0, out_valid=0. Each cycle:
    - if mplier[0], acc <= acc + mcand
    - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count+1
    - after exactly B_W BUSY cycles, go to DONE
    - fixed latency: no early exit on mplier==0
  - DONE: out_valid=1, result=acc, match=(acc == {B_W'b0, exp}).
    - result and match stay stable while out_ready=0.
    - When out_ready is high, the handshake completes and the next state is IDLE. out_valid drops the next cycle.
- Latency: accept at edge T, out_valid high from cycle T+B_W+1 (9 cycles with defaults). Minimum issue interval is B_W+2 cycles.
- Arithmetic:
  - All unsigned.
  - acc width Q_W+B_W cannot overflow: max (2^Q_W-1)*2^B_W < 2^(Q_W+B_W). No carry-out port.
  - Inputs are captured on accept, so later changes to them while BUSY or DONE are ignored.
- Boundary conditions:
  - divisor=0: result=remainder after full latency.
  - quotient=0: result=remainder.
  - in_valid high outside IDLE: ignored, not queued. in_ready stays 0.
  - DONE with out_ready high on the first DONE cycle: handshake completes that cycle.
  - In-flight operation and pending result are discarded on reset in any state; the next cycle is IDLE with out_valid=0.
  - The block does not accept new operands in the same cycle as an output handshake.
  - result/match hold their last value in IDLE/BUSY; they are only meaningful while out_valid=1.

Test Plan:
- Reset, then quotient=0x1234, divisor=0x56, remainder=0x0010, dividend=0x0000 -> out_valid exactly 9 cycles after accept, result=0x061D88, match=0.
- quotient=0xFFFF, divisor=0xFF, remainder=0xFFFF -> result=0xFFFF00, no overflow.
- divisor=0x00, quotient=0xABCD, remainder=0x0042 -> result=0x000042 after 9 cycles.
- Round-trip case:
  - dividend=1000, divisor=7, quotient=142, remainder=6 -> result=1000, match=1.
  - Repeat with dividend=1001 -> match=0.
- Backpressure and busy-ignore: hold out_ready=0 for 5 cycles in DONE -> out_valid, result and match stable. Drive in_valid with different operands throughout BUSY/DONE -> ignored, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst in the 4th BUSY cycle -> next cycle out_valid=0, result=0, in_ready=1. A fresh op (quotient=3, divisor=5, remainder=1) then returns 16.
